mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: widths, FSM states, grant owners
// and the registered memory-request payload.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Priority pick between fetch and data: data wins a tie unless it won last time.
// Only meaningful when at least one request is asserted.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  gnt_e last_gnt,
  output gnt_e gnt
);

  always_comb begin
    gnt = GNT_IF;
    if (if_req && d_req) begin
      gnt = (last_gnt == GNT_D) ? GNT_IF : GNT_D;
    end else if (d_req) begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and
// data access: IDLE -> ISSUE (mem_en) -> RESP (response pulse), 2 cycles/access.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  state_e            state_q;
  gnt_e              gnt_q;
  gnt_e              pick;
  mem_req_t          mem_q;
  mem_req_t          req_d;
  logic              mem_en_q;
  logic              if_valid_q;
  logic              d_done_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_cand;
  logic              d_cand;
  logic              grant;

  // The requester being answered in RESP is not eligible at that arbitration
  always_comb begin
    if_cand = if_req;
    d_cand  = d_req;
    if (state_q == ST_RESP) begin
      if (gnt_q == GNT_IF) begin
        if_cand = 1'b0;
      end else begin
        d_cand = 1'b0;
      end
    end
    grant = (state_q != ST_ISSUE) && (if_cand || d_cand);
  end

  arb_pick u_arb_pick (
    .if_req   (if_cand),
    .d_req    (d_cand),
    .last_gnt (gnt_q),
    .gnt      (pick)
  );

  always_comb begin
    req_d = '{we: 1'b0, addr: if_addr, wdata: '0, be: '1};
    if (pick == GNT_D) begin
      req_d = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_IF;
      mem_q      <= '0;
      mem_en_q   <= 1'b0;
      if_valid_q <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      if_valid_q <= 1'b0;
      d_done_q   <= 1'b0;
      if (if_valid_q) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_done_q && !mem_q.we) begin
        d_rdata_q <= mem_rdata;
      end
      case (state_q)
        ST_ISSUE: begin
          state_q    <= ST_RESP;
          if_valid_q <= (gnt_q == GNT_IF);
          d_done_q   <= (gnt_q == GNT_D);
        end
        default: begin
          if (grant) begin
            state_q  <= ST_ISSUE;
            gnt_q    <= pick;
            mem_q    <= req_d;
            mem_en_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Reset arriving during RESP suppresses the pulse already in flight
  assign if_valid  = if_valid_q & rst_n;
  assign d_done    = d_done_q & rst_n;
  assign if_rdata  = if_valid ? mem_rdata : if_rdata_q;
  assign d_rdata   = (d_done && !mem_q.we) ? mem_rdata : d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & mem_q.we;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;
  assign mem_be    = mem_q.be;
  assign stall     = (d_req & ~d_done) | (if_req & ~if_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        stall;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_chk;
  int          n_fail;
  logic [31:0] mem [int unsigned];

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      logic [31:0] w;
      w = mem.exists(mem_addr >> 2) ? mem[mem_addr >> 2] : 32'h0;
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        end
        mem[mem_addr >> 2] = w;
      end
      mem_rdata <= w;
    end
  end

  // Scoreboard: every response pulse must match the oldest expected response
  always @(negedge clk) begin
    if (if_valid || d_done) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: if_valid=%0b d_done=%0b with nothing expected", if_valid, d_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (d_done !== e.is_d || if_valid !== !e.is_d ||
            (e.is_d ? d_rdata : if_rdata) !== e.data) begin
          n_fail++;
          $display("FAIL sb_resp: got d_done=%0b if_valid=%0b if_rdata=%h d_rdata=%h, want is_d=%0b data=%h",
                   d_done, if_valid, if_rdata, d_rdata, e.is_d, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({mem_en, mem_we, if_valid, d_done, stall} !== 5'b0 || if_rdata !== 32'h0 ||
        d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%0b we=%0b iv=%0b dd=%0b stall=%0b ird=%h drd=%h addr=%h be=%h, want all 0",
               mem_en, mem_we, if_valid, d_done, stall, if_rdata, d_rdata, mem_addr, mem_be);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: mem_en=%0b, want 0", mem_en);
    end
  endtask

  task automatic test_fetch();
    if_addr = 32'h0000_0010;
    if_req  = 1'b1;
    sb.push_back('{1'b0, 32'h0000_0013});
    #1;
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_stall: stall=%0b, want 1", stall);
    end
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_issue: en=%0b addr=%h we=%0b iv=%0b, want 1 00000010 0 0", mem_en, mem_addr, mem_we, if_valid);
    end
    @(negedge clk);
    n_chk++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h13 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_resp: iv=%0b rdata=%h en=%0b, want 1 00000013 0", if_valid, if_rdata, mem_en);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (if_valid !== 1'b0 || if_rdata !== 32'h13 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_hold: iv=%0b rdata=%h en=%0b, want 0 00000013 0", if_valid, if_rdata, mem_en);
    end
  endtask

  task automatic test_both();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    if_addr = 32'h10;
    d_addr  = 32'h100;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    sb.push_back('{1'b1, 32'hCAFE_0100});
    sb.push_back('{1'b0, 32'h0000_0013});
    sb.push_back('{1'b1, 32'hCAFE_0100});
    sb.push_back('{1'b0, 32'h0000_0013});
    for (int k = 1; k <= 8; k++) begin
      logic [31:0] want_addr;
      logic [1:0]  want_pulse;
      @(negedge clk);
      n_chk++;
      if (k % 2 == 1) begin
        want_addr = (k % 4 == 1) ? 32'h100 : 32'h10;
        if (mem_en !== 1'b1 || mem_addr !== want_addr) begin
          n_fail++;
          $display("FAIL both_issue%0d: en=%0b addr=%h, want 1 %h", k, mem_en, mem_addr, want_addr);
        end
      end else begin
        want_pulse = (k % 4 == 2) ? 2'b10 : 2'b01;
        if ({d_done, if_valid} !== want_pulse || mem_en !== 1'b0) begin
          n_fail++;
          $display("FAIL both_resp%0d: d_done,if_valid=%b en=%0b, want %b 0", k, {d_done, if_valid}, mem_en, want_pulse);
        end
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL both_idle: en=%0b, want 0", mem_en);
    end
  endtask

  task automatic test_store();
    d_we    = 1'b1;
    d_addr  = 32'h200;
    d_wdata = 32'hDEAD_BEEF;
    d_be    = 4'b0011;
    d_req   = 1'b1;
    sb.push_back('{1'b1, 32'hCAFE_0100});
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
        mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_issue: en=%0b we=%0b be=%b addr=%h wdata=%h, want 1 1 0011 00000200 deadbeef",
               mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_chk++;
    if (d_done !== 1'b1 || d_rdata !== 32'hCAFE_0100) begin
      n_fail++;
      $display("FAIL store_done: d_done=%0b d_rdata=%h, want 1 cafe0100", d_done, d_rdata);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    d_req = 1'b1;
    sb.push_back('{1'b1, 32'h0000_BEEF});
    repeat (2) @(negedge clk);
    n_chk++;
    if (d_done !== 1'b1 || d_rdata !== 32'h0000_BEEF) begin
      n_fail++;
      $display("FAIL store_readback: d_done=%0b d_rdata=%h, want 1 0000beef", d_done, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (d_done !== 1'b0 || d_rdata !== 32'h0000_BEEF) begin
      n_fail++;
      $display("FAIL store_hold: d_done=%0b d_rdata=%h, want 0 0000beef", d_done, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int dcnt;
    bit prev_d;
    bit cur_d;
    bit done;
    dcnt    = 0;
    prev_d  = 1'b0;
    done    = 1'b0;
    if_addr = 32'h10;
    d_addr  = 32'h300;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, 32'h0000_0013});
      sb.push_back('{1'b1, {8'(8'h11 * (i + 1)), 8'(8'h11 * (i + 1)), 16'(16'h0300 + 4 * i)}});
    end
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      n_chk++;
      if (stall !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_stall: cycle %0d stall=%0b, want 1", c, stall);
      end
      if (mem_en) begin
        cur_d = (mem_addr != 32'h10);
        n_chk++;
        if (cur_d && prev_d) begin
          n_fail++;
          $display("FAIL b2b_alternate: cycle %0d data granted twice, addr=%h", c, mem_addr);
        end
        prev_d = cur_d;
      end
      if (d_done) begin
        dcnt++;
        if (dcnt == 3) begin
          d_req  = 1'b0;
          if_req = 1'b0;
          done   = 1'b1;
        end else begin
          d_addr = 32'h300 + 32'(4 * dcnt);
        end
      end
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL b2b_timeout: %0d data completions seen, want 3", dcnt);
      d_req  = 1'b0;
      if_req = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    if_addr = 32'h10;
    if_req  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (if_valid !== 1'b0 || d_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pulse: if_valid=%0b d_done=%0b, want 0 0", if_valid, d_done);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_en, if_valid, d_done} !== 3'b0 || if_rdata !== 32'h0 ||
        d_rdata !== 32'h0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: en=%0b iv=%0b dd=%0b ird=%h drd=%h addr=%h, want all 0",
               mem_en, if_valid, d_done, if_rdata, d_rdata, mem_addr);
    end
    rst_n  = 1'b1;
    d_addr = 32'h100;
    d_we   = 1'b0;
    d_req  = 1'b1;
    sb.push_back('{1'b1, 32'hCAFE_0100});
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL rstmid_issue: en=%0b addr=%h, want 1 00000100", mem_en, mem_addr);
    end
    @(negedge clk);
    n_chk++;
    if (d_done !== 1'b1 || d_rdata !== 32'hCAFE_0100) begin
      n_fail++;
      $display("FAIL rstmid_resp: d_done=%0b d_rdata=%h, want 1 cafe0100", d_done, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;
    d_be     = 4'h0;
    mem[32'h10 >> 2]  = 32'h0000_0013;
    mem[32'h100 >> 2] = 32'hCAFE_0100;
    mem[32'h300 >> 2] = 32'h1111_0300;
    mem[32'h304 >> 2] = 32'h2222_0304;
    mem[32'h308 >> 2] = 32'h3333_0308;

    test_reset();
    test_fetch();
    test_both();
    test_store();
    test_back_to_back();
    test_reset_mid();

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d responses never seen, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
